// File: rtl/mem_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_ctrl
// Description : Two-port arbiter and sequencer for the shared four-bank main
//               memory. Grants the icache (port 0) or dcache (port 1) miss
//               engine, issues one memory access for the owner, waits the
//               fixed read latency and returns a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   AW   address width
//   DW   data width
//   LAT  memory read latency, issue to valid mem_rdata (legal 1..7)
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin on ties (first tie goes to port 0)
//                  undefined -> fixed priority, port 1 wins ties
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   req[1:0]   request per port (bit0 icache, bit1 dcache)
//   wr[1:0]    per-port write flag
//   addr0/1    per-port address
//   wdata0/1   per-port write data
//   gnt[1:0]   one-hot grant while the port owns the memory
//   done[1:0]  one-cycle completion pulse to the owner
//   rdata      last captured read data (shared)
//   busy       high whenever the sequencer is not idle
//   mem_en     memory access strobe, one cycle per transaction
//   mem_wr     write qualifier for mem_en
//   mem_addr   memory address (latched)
//   mem_wdata  memory write data (latched)
//   mem_rdata  memory read data
// ============================================================================
module mem_arb_ctrl #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    wr,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // Counter starts at LAT-1 so the final WAIT cycle lines up with the
  // cycle in which the memory presents valid read data.
  localparam logic [2:0] c_CNT_LOAD = 3'(LAT - 1);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          w_pick;   // port that would win arbitration this cycle
  logic          w_accept; // a grant is taken this cycle

  assign w_accept = (state_q == c_IDLE) && (req != 2'b00);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_RR_EN
  // last_q holds the most recently granted port; it resets to port 1 so the
  // first tie after reset goes to port 0.
  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) begin
      w_pick = ~last_q;
    end else begin
      w_pick = req[1];
    end
  end

  always_comb begin
    last_d = last_q;
    if (w_accept) begin
      last_d = w_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: port 1 wins whenever it is requesting.
  always_comb begin
    w_pick = req[1];
  end
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (req != 2'b00) state_d = c_ISSUE;
      c_ISSUE: state_d = c_WAIT;
      c_WAIT:  if (cnt_q == 3'd0) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    gnt    = 2'b00;
    done   = 2'b00;
    busy   = 1'b0;
    mem_en = 1'b0;
    mem_wr = 1'b0;
    if (state_q != c_IDLE) begin
      busy = 1'b1;
      gnt  = owner_q ? 2'b10 : 2'b01;
    end
    if (state_q == c_ISSUE) begin
      mem_en = 1'b1;
      mem_wr = wr_q;
    end
    if (state_q == c_DONE) begin
      done = owner_q ? 2'b10 : 2'b01;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

  // --------------------------------------------------------------------------
  // Datapath next-state: request latch, latency counter, read capture
  // --------------------------------------------------------------------------
  always_comb begin
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    // The owner's request fields are frozen here; requesters may change
    // them freely once the transaction completes.
    if (w_accept) begin
      owner_d = w_pick;
      wr_d    = w_pick ? wr[1]  : wr[0];
      addr_d  = w_pick ? addr1  : addr0;
      wdata_d = w_pick ? wdata1 : wdata0;
    end

    if (state_q == c_ISSUE) begin
      cnt_d = c_CNT_LOAD;
    end

    if (state_q == c_WAIT) begin
      cnt_d = cnt_q - 3'd1;
      // Writes leave the shared read-data register untouched.
      if ((cnt_q == 3'd0) && !wr_q) begin
        rdata_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire
